picoram_bus_arbiter: RTL

Two-master arbiter sharing the single-port on-chip SRAM (picosoc_mem-style macro: byte write enables, synchronous one-cycle read) between the PicoRV32 native memory bus (master 0) and a secondary master such as a DMA or boot loader (master 1). Both masters use the native valid/ready handshake. The block sits between the masters and the RAM macro, replacing direct CPU-to-RAM wiring. It also checks each address against the RAM range and flags accesses that fall outside it.

---
 rtl/picoram_bus_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/picoram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : picoram_bus_arbiter
// Description : Two-master valid/ready arbiter for a single-port on-chip SRAM
//               macro with byte write enables and a one-cycle synchronous
//               read. Master 0 is the PicoRV32 native bus and master 1 is a
//               secondary master (DMA / boot loader). Accesses that fall
//               outside the RAM range are suppressed and reported.
// Revision    : 1.0 - initial release
// ============================================================================
module picoram_bus_arbiter #(
    parameter int MEM_WORDS      = 65536,
    parameter int AW             = 22,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          m0_valid,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wstrb,
    output logic          m0_ready,
    output logic [31:0]   m0_rdata,

    input  logic          m1_valid,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wstrb,
    output logic          m1_ready,
    output logic [31:0]   m1_rdata,

    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,

    output logic          err_pulse,
    output logic [31:0]   err_addr,
    output logic          err_master
);

    // First byte address past the end of the RAM; 33 bits so that a RAM
    // filling the whole 32-bit space still compares correctly.
    localparam logic [32:0] c_RAM_BYTES = 33'(MEM_WORDS) << 2;

    // One request is issued in IDLE; its response (and the RAM read data)
    // is returned in RESP.
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RESP = 1'b1;

    logic [0:0]  r_state;
    logic        r_grant;
    logic        r_oor;
    logic        r_last_grant;
    logic        r_m0_ready;
    logic        r_m1_ready;
    logic        r_err_pulse;
    logic [31:0] r_err_addr;
    logic        r_err_master;

    logic        w_req_any;
    logic        w_tie_winner;
    logic        w_winner;
    logic        w_sel;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_wstrb;
    logic        w_sel_oor;

    assign w_req_any = m0_valid | m1_valid;

    // Tie-break when both masters request in the same IDLE cycle.
    generate
        if (FIXED_PRIORITY) begin : g_fixed_priority
            assign w_tie_winner = 1'b0;
        end else begin : g_round_robin
            // The master that did not win last time goes first.
            assign w_tie_winner = ~r_last_grant;
        end
    endgenerate

    // Pick the winner among the currently valid requests.
    always_comb begin
        w_winner = 1'b0;
        if (m0_valid && m1_valid) begin
            w_winner = w_tie_winner;
        end else if (m1_valid) begin
            w_winner = 1'b1;
        end
    end

    // In IDLE the RAM port follows the live winner; in RESP it stays on the
    // granted master so the port does not wander while the read completes.
    assign w_sel = (r_state == c_ST_IDLE) ? w_winner : r_grant;

    // Route the selected master's request fields to the RAM side.
    always_comb begin
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        w_sel_wstrb = m0_wstrb;
        if (w_sel) begin
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
            w_sel_wstrb = m1_wstrb;
        end
    end

    assign w_sel_oor = ({1'b0, w_sel_addr} >= c_RAM_BYTES);

    assign ram_addr  = w_sel_addr[AW+1:2];
    assign ram_wdata = w_sel_wdata;

    // Write strobes only reach the macro for an in-range request being
    // issued in IDLE, and never while reset is held.
    assign ram_wen = (reset_n && (r_state == c_ST_IDLE) && w_req_any && !w_sel_oor)
                   ? w_sel_wstrb : 4'b0000;

    // Arbitration state machine with registered ready and error outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= 1'b0;
            r_oor        <= 1'b0;
            r_last_grant <= 1'b1;
            r_m0_ready   <= 1'b0;
            r_m1_ready   <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_addr   <= 32'h0000_0000;
            r_err_master <= 1'b0;
        end else begin
            r_m0_ready  <= 1'b0;
            r_m1_ready  <= 1'b0;
            r_err_pulse <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req_any) begin
                        r_state      <= c_ST_RESP;
                        r_grant      <= w_winner;
                        r_oor        <= w_sel_oor;
                        r_last_grant <= w_winner;
                        r_m0_ready   <= ~w_winner;
                        r_m1_ready   <= w_winner;
                        // The error report becomes visible together with
                        // the ready pulse of the offending access.
                        if (w_sel_oor) begin
                            r_err_pulse  <= 1'b1;
                            r_err_addr   <= w_sel_addr;
                            r_err_master <= w_winner;
                        end
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Read data is only presented during the granted master's ready pulse;
    // an out-of-range read returns zero instead of whatever the macro drove.
    assign m0_rdata = (r_m0_ready && !r_oor) ? ram_rdata : 32'h0000_0000;
    assign m1_rdata = (r_m1_ready && !r_oor) ? ram_rdata : 32'h0000_0000;

    assign m0_ready   = r_m0_ready;
    assign m1_ready   = r_m1_ready;
    assign err_pulse  = r_err_pulse;
    assign err_addr   = r_err_addr;
    assign err_master = r_err_master;

endmodule
`default_nettype wire
